// File: rtl/intr_host_agent.sv
// rtl/intr_host_agent.sv - APB initiator for priority registers plus interrupt service responder
//
// Optional feature macro: INTR_HOST_TIMEOUT_EN. When defined, an ACCESS phase
// that sees TIMEOUT_CYCLES consecutive cycles with pready_i low is aborted and
// reported as an error. When undefined, ACCESS waits for pready_i forever.
//
// Ports:
//   pclk_i, prst_i               clock (rising edge), asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_write_i, cmd_addr_i, cmd_wdata_i   command direction, address, write data
//   rsp_valid_o, rsp_rdata_o, rsp_err_o    one-cycle completion, read data, error
//   paddr_o, pwdata_o, pwrite_o, psel_o, penable_o   APB request
//   prdata_i, pready_i, pslverr_i          APB completion
//   intr_valid_i, intr_id_i      interrupt presented by the controller (level)
//   intr_serviced_o              one-cycle service-done pulse
//   last_intr_o, serviced_cnt_o  last serviced ID, saturating serviced count
module intr_host_agent #(
  parameter int unsigned NUM_INTR       = 16,
  parameter int unsigned SERVICE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [7:0]  cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [7:0]  paddr_o,
  output logic [7:0]  pwdata_o,
  output logic        pwrite_o,
  output logic        psel_o,
  output logic        penable_o,
  input  logic [7:0]  prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  input  logic        intr_valid_i,
  input  logic [3:0]  intr_id_i,
  output logic        intr_serviced_o,
  output logic [3:0]  last_intr_o,
  output logic [15:0] serviced_cnt_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
  typedef enum logic [1:0] {S_WAIT, S_SERVICE, S_RELEASE} svc_state_t;

  localparam logic [8:0]  NUM_INTR_W = 9'(NUM_INTR);
  localparam int unsigned SVC_W      = $clog2(SERVICE_CYCLES + 1);

  // Parameter sanity guard: an illegal configuration elaborates this named
  // scope, which makes it visible in the hierarchy of a bad integration.
  if (TIMEOUT_CYCLES < 2 || SERVICE_CYCLES < 1) begin : g_illegal_params
  end

  // ---------------------------------------------------------------- APB engine
  apb_state_t state, state_nxt;
  logic       err_q;
  logic       legal;
  logic       timeout;

  assign legal = ({1'b0, cmd_addr_i} < NUM_INTR_W);

`ifdef INTR_HOST_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // Counts ACCESS cycles of the current transfer; cleared in every other state.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i)                to_cnt <= '0;
    else if (state == ACCESS)  to_cnt <= to_cnt + TO_W'(1);
    else                       to_cnt <= '0;
  end

  assign timeout = (state == ACCESS) && !pready_i &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cmd_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_nxt = legal ? SETUP : RESP;
      end
      SETUP: begin
        psel_o    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state       <= IDLE;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      err_q       <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid_i) begin
        pwrite_o <= cmd_write_i;
        paddr_o  <= cmd_addr_i;
        pwdata_o <= cmd_wdata_i;
        err_q    <= !legal;
        // An illegal read still completes as an errored read.
        if (!legal && !cmd_write_i) rsp_rdata_o <= '0;
      end
      if (state == ACCESS) begin
        if (pready_i) begin
          err_q <= pslverr_i;
          if (!pwrite_o) rsp_rdata_o <= pslverr_i ? 8'h00 : prdata_i;
        end else if (timeout) begin
          err_q       <= 1'b1;
          rsp_rdata_o <= '0;
        end
      end
    end
  end

  // ------------------------------------------------------------ service engine
  svc_state_t       svc_state, svc_state_nxt;
  logic [SVC_W-1:0] svc_cnt;
  logic [3:0]       id_q;

  always_comb begin
    svc_state_nxt   = svc_state;
    intr_serviced_o = 1'b0;
    case (svc_state)
      S_WAIT:    if (intr_valid_i) svc_state_nxt = S_SERVICE;
      S_SERVICE: begin
        if (svc_cnt == SVC_W'(1)) begin
          intr_serviced_o = 1'b1;
          svc_state_nxt   = S_RELEASE;
        end
      end
      // Holding here until valid drops keeps one presentation from being
      // serviced twice.
      S_RELEASE: if (!intr_valid_i) svc_state_nxt = S_WAIT;
      default:   svc_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      svc_state      <= S_WAIT;
      svc_cnt        <= '0;
      id_q           <= '0;
      last_intr_o    <= '0;
      serviced_cnt_o <= '0;
    end else begin
      svc_state <= svc_state_nxt;
      if (svc_state == S_WAIT && intr_valid_i) begin
        id_q    <= intr_id_i;
        svc_cnt <= SVC_W'(SERVICE_CYCLES);
      end
      if (svc_state == S_SERVICE) begin
        svc_cnt <= svc_cnt - SVC_W'(1);
        if (intr_serviced_o) begin
          last_intr_o <= id_q;
          if (serviced_cnt_o != 16'hFFFF) serviced_cnt_o <= serviced_cnt_o + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_intr_host_agent.sv
// tb/tb_intr_host_agent.sv - self-checking bench for intr_host_agent
module tb_intr_host_agent;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [7:0]  paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;
  logic        intr_valid, intr_serviced;
  logic [3:0]  intr_id, last_intr;
  logic [15:0] serviced_cnt;

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;

  always #5 pclk = ~pclk;

  intr_host_agent dut (
    .pclk_i(pclk), .prst_i(prst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel),
    .penable_o(penable), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
    .intr_valid_i(intr_valid), .intr_id_i(intr_id), .intr_serviced_o(intr_serviced),
    .last_intr_o(last_intr), .serviced_cnt_o(serviced_cnt)
  );

  always @(negedge pclk) if (intr_serviced === 1'b1) pulse_total++;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    logic       slverr;
    int         waits;
    int         exp_lat;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Issues one command at cycle 0 and plays a slave that inserts v.waits wait
  // states, checking the APB/response waveform cycle by cycle.
  task automatic run_cmd(input vec_t v, input string tag);
    bit   legal, pat_ok, req_ok;
    bit   exp_psel, exp_pen;
    int   w, lat;
    logic err;
    logic [7:0] rdata;
    legal  = (v.addr < 8'd16);
    pat_ok = 1'b1;
    req_ok = 1'b1;
    w      = 0;
    lat    = -1;
    err    = 1'b0;
    rdata  = 8'h00;
    check({tag, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    for (int c = 1; c <= 60; c++) begin
      tick();
      cmd_valid = 1'b0;
      exp_psel = legal && (c >= 1) && (c <= 2 + v.waits);
      exp_pen  = legal && (c >= 2) && (c <= 2 + v.waits);
      if (psel !== exp_psel || penable !== exp_pen || rsp_valid !== (c == v.exp_lat)) pat_ok = 1'b0;
      if (psel === 1'b1 && (paddr !== v.addr || pwrite !== v.wr || (v.wr && pwdata !== v.wdata)))
        req_ok = 1'b0;
      if (psel === 1'b1 && penable === 1'b1) begin
        pready  = (w == v.waits);
        prdata  = pready ? v.prdata : 8'hEE;
        pslverr = pready ? v.slverr : 1'b0;
        w++;
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = 8'hEE;
      end
      if (rsp_valid === 1'b1) begin
        lat = c; err = rsp_err; rdata = rsp_rdata;
        break;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " waveform"}, pat_ok, 1);
    check({tag, " apb request"}, req_ok, 1);
    check({tag, " rsp_err"}, err, v.exp_err);
    check({tag, " rsp_rdata"}, rdata, v.exp_rdata);
    tick();
    check({tag, " ready again"}, cmd_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bad, lat, pulse_at, npulse, snap;
    prst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    prdata = 0; pready = 0; pslverr = 0; intr_valid = 0; intr_id = 0;

    //      wr    addr   wdata  prdata slverr w  lat err   rdata
    vecs[0] = '{1'b1, 8'd3,   8'h5A, 8'h00, 1'b0, 0, 3, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'd3,   8'h00, 8'h5A, 1'b0, 1, 4, 1'b0, 8'h5A};
    vecs[2] = '{1'b0, 8'd3,   8'h00, 8'h5A, 1'b1, 1, 4, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 8'd5,   8'h00, 8'hC3, 1'b0, 0, 3, 1'b0, 8'hC3};
    vecs[4] = '{1'b1, 8'd15,  8'h77, 8'h00, 1'b1, 2, 5, 1'b1, 8'hC3};
    vecs[5] = '{1'b1, 8'd16,  8'h12, 8'h00, 1'b0, 0, 1, 1'b1, 8'hC3};
    vecs[6] = '{1'b0, 8'd255, 8'h00, 8'h00, 1'b0, 0, 1, 1'b1, 8'h00};
    vecs[7] = '{1'b0, 8'd0,   8'h00, 8'h81, 1'b0, 3, 6, 1'b0, 8'h81};
    vecs[8] = '{1'b1, 8'd1,   8'hA5, 8'h00, 1'b0, 0, 3, 1'b0, 8'h81};

    tick(); tick();
    check("reset cmd_ready", cmd_ready, 1);
    check("reset psel", psel, 0);
    check("reset penable", penable, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset paddr", paddr, 0);
    check("reset intr_serviced", intr_serviced, 0);
    check("reset last_intr", last_intr, 0);
    check("reset serviced_cnt", serviced_cnt, 0);
    prst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Slave that never answers.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'd2;
    tick(); cmd_valid = 1'b0;
    tick();
    check("stall in access", {psel, penable}, 2'b11);
`ifdef INTR_HOST_TIMEOUT_EN
    lat = -1;
    for (int c = 3; c <= 100; c++) begin
      tick();
      if (rsp_valid === 1'b1) begin lat = c; break; end
    end
    check("timeout latency", lat, 18);
    check("timeout rsp_err", rsp_err, 1);
    check("timeout rsp_rdata", rsp_rdata, 0);
    check("timeout psel dropped", psel, 0);
`else
    bad = 0;
    for (int c = 3; c <= 102; c++) begin
      tick();
      if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) bad++;
    end
    check("no timeout after 100", bad, 0);
    pready = 1'b1; prdata = 8'h3C;
    tick();
    pready = 1'b0;
    check("late ready rsp_valid", rsp_valid, 1);
    check("late ready rsp_rdata", rsp_rdata, 8'h3C);
    check("late ready rsp_err", rsp_err, 0);
`endif
    tick();

    // Reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'd4; cmd_wdata = 8'h44;
    tick(); cmd_valid = 1'b0;
    tick();
    check("pre-reset access", {psel, penable}, 2'b11);
    #2 prst = 1'b1;
    #1;
    check("async reset psel/penable", {psel, penable}, 2'b00);
    check("async reset cmd_ready", cmd_ready, 1);
    tick();
    prst = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    check("no response after reset", bad, 0);

    // Interrupt service, valid dropped one cycle after the pulse.
    intr_valid = 1'b1; intr_id = 4'd7;
    pulse_at = -1; npulse = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (intr_serviced === 1'b1) begin pulse_at = c; npulse++; end
      if (c == 5) intr_valid = 1'b0;
    end
    check("service pulse cycle", pulse_at, 4);
    check("service pulse count", npulse, 1);
    check("last_intr", last_intr, 7);
    check("serviced_cnt", serviced_cnt, 1);

    // Valid held high, with a command accepted in the same cycle.
    snap = pulse_total;
    intr_valid = 1'b1; intr_id = 4'd9;
    run_cmd('{1'b1, 8'd6, 8'h11, 8'h00, 1'b0, 0, 3, 1'b0, 8'h00}, "concurrent");
    for (int c = 0; c < 20; c++) tick();
    check("held valid single pulse", pulse_total - snap, 1);
    check("held valid serviced_cnt", serviced_cnt, 2);
    check("held valid last_intr", last_intr, 9);
    intr_valid = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_host_agent.md
# intr_host_agent

Processor-side counterpart of the interrupt controller. The block is an APB initiator that turns a simple command port into APB write and read transfers to the controller's priority registers. It also acts as the interrupt responder: it accepts `intr_valid_i`/`intr_id_i`, models a fixed service time, then pulses `intr_serviced_o`. Both engines run independently on one clock.

## Interface
- `NUM_INTR`, 16: number of priority registers; legal addresses are 0..NUM_INTR-1.
- `SERVICE_CYCLES`, 4: cycles spent servicing one interrupt; must be ≥1.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS-phase cycles before abort; must be ≥2.
- `pclk_i` in 1: clock; all logic on its rising edge.
- `prst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i` and `cmd_ready_o` are both high.
- `cmd_write_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in 8: register address.
- `cmd_wdata_i` in 8: write data.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 8: read data; held until the next response.
- `rsp_err_o` out 1: error flag, valid with `rsp_valid_o`.
- `paddr_o` out 8: APB address.
- `pwdata_o` out 8: APB write data.
- `pwrite_o` out 1: APB direction.
- `psel_o` out 1: APB select.
- `penable_o` out 1: APB enable.
- `prdata_i` in 8: APB read data.
- `pready_i` in 1: APB ready.
- `pslverr_i` in 1: APB slave error.
- `intr_valid_i` in 1: interrupt presented by the controller (level).
- `intr_id_i` in 4: interrupt number.
- `intr_serviced_o` out 1: service-done pulse to the controller.
- `last_intr_o` out 4: ID of the last interrupt serviced.
- `serviced_cnt_o` out 16: count of serviced interrupts; saturates at 0xFFFF.

## Operation
- **APB FSM states:** IDLE, SETUP, ACCESS, RESP.
  - IDLE: `cmd_ready_o`=1. On handshake, latch write/addr/wdata.
    - Legal address: go to SETUP.
    - `cmd_addr_i` ≥ NUM_INTR: go to RESP with error; no APB transfer is issued.
  - SETUP: `psel_o`=1, `penable_o`=0, `paddr_o`/`pwrite_o`/`pwdata_o` driven from the latched command. Next state is ACCESS.
  - ACCESS: `psel_o`=1, `penable_o`=1; address and data held stable.
    - `pready_i`=1 sampled: capture `prdata_i` (reads only) and `pslverr_i`, then go to RESP.
  - RESP: `rsp_valid_o`=1 for one cycle; `psel_o`=`penable_o`=0. Next state is IDLE.
- `rsp_err_o` = `pslverr_i` for a completed transfer, 1 for an illegal address or timeout, otherwise 0.
- `rsp_rdata_o` updates only on a successful read. It is 0 after an errored read and unchanged after a write.
- **Service FSM states:** WAIT, SERVICE, RELEASE.
  - WAIT: on `intr_valid_i`=1, latch `intr_id_i`, load the down-counter with SERVICE_CYCLES, go to SERVICE.
  - SERVICE: decrement the counter each cycle. When it reaches 1, assert `intr_serviced_o` for exactly one cycle, update `last_intr_o`, increment `serviced_cnt_o` (saturating), go to RELEASE.
  - RELEASE: wait for `intr_valid_i`=0, then go to WAIT. This prevents servicing the same presentation twice.
  - Back-to-back interrupts: a new presentation is recognised only after valid has been seen low.
- The two FSMs share no state. A command and an interrupt arriving in the same cycle are both accepted.

## Timing
- **Reset values:** all outputs 0, except `cmd_ready_o`=1. FSMs go to IDLE and WAIT. Asserting reset mid-transfer drops `psel_o`/`penable_o` immediately and no response is issued.
- **Legal command, zero-wait slave:** accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2 with `pready_i`=1, `rsp_valid_o` at cycle 3, `cmd_ready_o`=1 again at cycle 4.
  - Each ACCESS cycle with `pready_i`=0 adds one cycle.
- **Illegal address:** accept at cycle 0, `rsp_valid_o` at cycle 1 with `rsp_err_o`=1.
- **Interrupt service:** `intr_valid_i` seen high at cycle 0, `intr_serviced_o` high at cycle SERVICE_CYCLES.

## Configuration
- **`INTR_HOST_TIMEOUT_EN` defined:**
  - A counter runs during ACCESS.
  - After TIMEOUT_CYCLES consecutive ACCESS cycles with `pready_i`=0, the transfer aborts to RESP with `rsp_err_o`=1 and `rsp_rdata_o`=0.
  - `psel_o` drops in the RESP cycle.
- **Undefined:** no counter; ACCESS waits for `pready_i` indefinitely and the timeout parameter is ignored.

## Test plan
- Write addr 3 data 0x5A with a zero-wait slave → `psel_o` high at cycles 1-2, `penable_o` at cycle 2, `rsp_valid_o` at cycle 3 with `rsp_err_o`=0.
- Read addr 3 with the slave returning 0x5A after one wait state → `rsp_valid_o` at cycle 4, `rsp_rdata_o`=0x5A. Repeat with `pslverr_i`=1 → `rsp_err_o`=1, `rsp_rdata_o`=0.
- Command to addr 16 with NUM_INTR=16 → no `psel_o`, `rsp_valid_o`=1 and `rsp_err_o`=1 at cycle 1.
- With `INTR_HOST_TIMEOUT_EN` and `pready_i` tied 0 → abort after 16 ACCESS cycles with `rsp_err_o`=1. Without the macro → still in ACCESS after 100 cycles.
- `intr_valid_i`=1, `intr_id_i`=7, SERVICE_CYCLES=4, valid dropped one cycle after the pulse → `intr_serviced_o` pulses at cycle 4, `last_intr_o`=7, `serviced_cnt_o`=1. Holding valid high → no second pulse.
- Assert `prst_i` during ACCESS → `psel_o`=`penable_o`=0 immediately, `cmd_ready_o`=1, no `rsp_valid_o`.
